cache_mem_arbiter: RTL and testbench

Arbitrates the single shared RAM port between the instruction cache (read-only) and the data cache (read/write) inside the caches block. Grants ownership to one requester, holds it until the RAM reports the access complete, and returns the RAM data and completion (wait deassert) to the owner only. Sits between the icache/dcache miss paths and the memory-side port.

---
 rtl/cache_mem_arbiter_if.sv | 62 ++++++
 rtl/cache_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Bundles every bus signal around the shared RAM port arbiter: the icache and
// dcache miss-path request/response signals and the memory-side RAM port.
//
// Modports:
//   master : arbiter view. Takes the cache requests and RAM responses as
//            inputs and drives the cache responses and RAM commands.
//   slave  : environment view (icache, dcache and RAM together). Opposite
//            directions to master.
//
// Signals (ADDR_W / DATA_W wide where not 1 bit):
//   iREN, iaddr                  icache read request and address
//   iwait, iload                 icache wait and read data
//   dREN, dWEN, daddr, dstore    dcache read/write request, address, write data
//   dwait, dload                 dcache wait and read data
//   ramREN, ramWEN, ramaddr,
//   ramstore                     RAM command port
//   ramload, ramstate            RAM read data and status (FREE/BUSY/ACCESS/ERROR)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr,
        output iwait, iload,
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        output iREN, iaddr,
        input  iwait, iload,
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Arbitrates the single shared RAM port between the read-only instruction
// cache and the read/write data cache. One requester owns the port from the
// cycle after it is granted until the RAM reports ACCESS (completion) or the
// owner withdraws its request; every grant returns through IDLE, which is the
// one-cycle arbitration turnaround.
//
// Optional feature macro:
//   CACHE_ARB_RR_EN  defined  : round-robin on simultaneous requests (the side
//                               that did not complete last wins).
//                    undefined: fixed priority, the dcache wins every tie.
//
// Ports:
//   CLK  in  system clock, rising edge
//   RST  in  synchronous active-high reset
//   bus      cache_mem_arbiter_if.master (cache requests/responses + RAM port)
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    cache_mem_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IGRANT = 2'd1,
        ST_DGRANT = 2'd2
    } state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;   // 1 when the dcache completed the last access

    logic ireq;
    logic dreq;
    logic access;
    logic i_done;
    logic d_done;

    logic              ram_ren_c;
    logic              ram_wen_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_store_c;
    logic [DATA_W-1:0] iload_c;
    logic [DATA_W-1:0] dload_c;
    logic              iwait_c;
    logic              dwait_c;

    assign ireq   = bus.iREN;
    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RAM_ACCESS);

    // Completion needs the owner still requesting in the ACCESS cycle.
    assign i_done = (state_q == ST_IGRANT) && access && ireq;
    assign d_done = (state_q == ST_DGRANT) && access && dreq;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            ST_IDLE: begin
                if (ireq && dreq) begin
`ifdef CACHE_ARB_RR_EN
                    state_d = last_d_q ? ST_IGRANT : ST_DGRANT;
`else
                    state_d = ST_DGRANT;
`endif
                end else if (dreq) begin
                    state_d = ST_DGRANT;
                end else if (ireq) begin
                    state_d = ST_IGRANT;
                end
            end
            ST_IGRANT: begin
                // A withdrawn request is not a completion: last_d untouched.
                if (!ireq) begin
                    state_d = ST_IDLE;
                end else if (access) begin
                    state_d  = ST_IDLE;
                    last_d_d = 1'b0;
                end
            end
            ST_DGRANT: begin
                if (!dreq) begin
                    state_d = ST_IDLE;
                end else if (access) begin
                    state_d  = ST_IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ram_ren_c   = 1'b0;
        ram_wen_c   = 1'b0;
        ram_addr_c  = '0;
        ram_store_c = '0;
        case (state_q)
            ST_IGRANT: begin
                ram_ren_c  = bus.iREN;
                ram_addr_c = bus.iaddr;
            end
            ST_DGRANT: begin
                ram_addr_c  = bus.daddr;
                ram_store_c = bus.dstore;
                // Write takes precedence when both enables are raised.
                ram_wen_c   = bus.dWEN;
                ram_ren_c   = bus.dREN & ~bus.dWEN;
            end
            default: begin
            end
        endcase

        iwait_c = ireq & ~((state_q == ST_IGRANT) && access);
        dwait_c = dreq & ~((state_q == ST_DGRANT) && access);
        iload_c = i_done ? bus.ramload : '0;
        dload_c = d_done ? bus.ramload : '0;
    end

    assign bus.ramREN   = ram_ren_c;
    assign bus.ramWEN   = ram_wen_c;
    assign bus.ramaddr  = ram_addr_c;
    assign bus.ramstore = ram_store_c;
    assign bus.iwait    = iwait_c;
    assign bus.iload    = iload_c;
    assign bus.dwait    = dwait_c;
    assign bus.dload    = dload_c;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. A table of per-cycle records
// (inputs for the cycle, expected combinational outputs before the next edge)
// walks the arbiter through single-requester reads/writes, ERROR retries,
// request withdrawal, ties and a mid-grant reset. A hand-written sequence then
// checks the owner order across four back-to-back contended accesses.
// Expectations follow CACHE_ARB_RR_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef struct {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rs;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
    } vec_t;

    logic CLK;
    logic RST;
    int   total;
    int   bad;
    vec_t vecs[$];

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(
        input logic rst, input logic iren, input logic [31:0] iaddr,
        input logic dren, input logic dwen, input logic [31:0] daddr,
        input logic [31:0] dstore, input logic [31:0] ramload, input logic [1:0] rs,
        input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
        input logic [31:0] e_store, input logic e_iwait, input logic [31:0] e_iload,
        input logic e_dwait, input logic [31:0] e_dload);
        vec_t v;
        v.rst = rst; v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen;
        v.daddr = daddr; v.dstore = dstore; v.ramload = ramload; v.rs = rs;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
        v.e_iwait = e_iwait; v.e_iload = e_iload; v.e_dwait = e_dwait; v.e_dload = e_dload;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic iren, input logic [31:0] iaddr,
                         input logic dren, input logic dwen, input logic [31:0] daddr,
                         input logic [31:0] dstore, input logic [31:0] ramload,
                         input logic [1:0] rs);
        RST          = rst;
        bus.iREN     = iren;
        bus.iaddr    = iaddr;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.daddr    = daddr;
        bus.dstore   = dstore;
        bus.ramload  = ramload;
        bus.ramstate = rs;
    endtask

    initial begin
        vec_t v;
        logic exp_d;
        logic [31:0] val;
        total = 0;
        bad   = 0;

        // Reset, then an icache read with 2 BUSY cycles before ACCESS
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h40,   0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h40,   0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h40,   0, 0, 0, 0, 0, RS_BUSY,  1, 0, 'h40, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h40,   0, 0, 0, 0, 0, RS_BUSY,  1, 0, 'h40, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h40,   0, 0, 0, 0, 'hDEADBEEF, RS_ACCESS, 1, 0, 'h40, 0, 0, 'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 0, 0, 0, 0));
        // icache read with 3 ERROR cycles: wait held high, no data leaks out
        vecs.push_back(mk(0, 1, 'h100,  0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h100,  0, 0, 0, 0, 'hBAD0BAD0, RS_ERROR, 1, 0, 'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h100,  0, 0, 0, 0, 'hBAD0BAD0, RS_ERROR, 1, 0, 'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h100,  0, 0, 0, 0, 'hBAD0BAD0, RS_ERROR, 1, 0, 'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h100,  0, 0, 0, 0, 'hCAFEF00D, RS_ACCESS, 1, 0, 'h100, 0, 0, 'hCAFEF00D, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 0, 0, 0, 0));
        // dcache read+write: write wins; pending icache stays waiting
        vecs.push_back(mk(0, 0, 0,      1, 1, 'h80, 'h1234, 0, RS_FREE, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'h44,   1, 1, 'h80, 'h1234, 0, RS_BUSY, 0, 1, 'h80, 'h1234, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'h44,   1, 1, 'h80, 'h1234, 'h55, RS_ACCESS, 0, 1, 'h80, 'h1234, 1, 0, 0, 'h55));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 0, 0, 0, 0));
        // dcache owner withdraws during BUSY with icache pending (last_d stays 1)
        vecs.push_back(mk(0, 0, 0,      1, 0, 'h200, 0, 0, RS_FREE, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'h300,  1, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h200, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'h300,  0, 0, 'h200, 0, 0, RS_BUSY, 0, 0, 'h200, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h300,  0, 0, 'h200, 0, 0, RS_BUSY, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h300,  0, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h300, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 'h300,  0, 0, 'h200, 0, 0, RS_BUSY, 0, 0, 'h300, 0, 0, 0, 0, 0));
        // Tie with last_d=1, then reset mid-grant during BUSY
        vecs.push_back(mk(0, 1, 'h300,  1, 0, 'h200, 0, 0, RS_FREE, 0, 0, 0, 0, 1, 0, 1, 0));
`ifdef CACHE_ARB_RR_EN
        vecs.push_back(mk(0, 1, 'h300,  1, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h300, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 'h300,  1, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h300, 0, 1, 0, 1, 0));
`else
        vecs.push_back(mk(0, 1, 'h300,  1, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h200, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 'h300,  1, 0, 'h200, 0, 0, RS_BUSY, 1, 0, 'h200, 0, 1, 0, 1, 0));
`endif
        vecs.push_back(mk(0, 0, 0,      1, 0, 'h200, 0, 0, RS_BUSY, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, RS_BUSY,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0, 0, RS_FREE,  0, 0, 0, 0, 0, 0, 0, 0));

        drive(1, 0, 0, 0, 0, 0, 0, 0, RS_FREE);
        repeat (2) @(posedge CLK);

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            @(negedge CLK);
            drive(v.rst, v.iren, v.iaddr, v.dren, v.dwen, v.daddr, v.dstore, v.ramload, v.rs);
            #1;
            chk($sformatf("row%0d ramREN", r),   {31'd0, bus.ramREN}, {31'd0, v.e_ren});
            chk($sformatf("row%0d ramWEN", r),   {31'd0, bus.ramWEN}, {31'd0, v.e_wen});
            chk($sformatf("row%0d ramaddr", r),  bus.ramaddr,         v.e_addr);
            chk($sformatf("row%0d ramstore", r), bus.ramstore,        v.e_store);
            chk($sformatf("row%0d iwait", r),    {31'd0, bus.iwait},  {31'd0, v.e_iwait});
            chk($sformatf("row%0d iload", r),    bus.iload,           v.e_iload);
            chk($sformatf("row%0d dwait", r),    {31'd0, bus.dwait},  {31'd0, v.e_dwait});
            chk($sformatf("row%0d dload", r),    bus.dload,           v.e_dload);
        end

        // Four contended accesses; last_d is 0 after the reset above.
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            val = 32'h1000 + k;
            @(negedge CLK);
            drive(0, 1, 'hA0, 1, 0, 'hB0, 0, 0, RS_FREE);
            #1;
            chk($sformatf("tie%0d idle ramREN", k), {31'd0, bus.ramREN}, 32'd0);
            chk($sformatf("tie%0d idle iwait", k),  {31'd0, bus.iwait},  32'd1);
            chk($sformatf("tie%0d idle dwait", k),  {31'd0, bus.dwait},  32'd1);
            @(negedge CLK);
            drive(0, 1, 'hA0, 1, 0, 'hB0, 0, 0, RS_BUSY);
            #1;
            chk($sformatf("tie%0d owner addr", k), bus.ramaddr, exp_d ? 32'hB0 : 32'hA0);
            chk($sformatf("tie%0d ramREN", k), {31'd0, bus.ramREN}, 32'd1);
            @(negedge CLK);
            drive(0, 1, 'hA0, 1, 0, 'hB0, 0, val, RS_ACCESS);
            #1;
            chk($sformatf("tie%0d iwait", k), {31'd0, bus.iwait}, exp_d ? 32'd1 : 32'd0);
            chk($sformatf("tie%0d dwait", k), {31'd0, bus.dwait}, exp_d ? 32'd0 : 32'd1);
            chk($sformatf("tie%0d iload", k), bus.iload, exp_d ? 32'd0 : val);
            chk($sformatf("tie%0d dload", k), bus.dload, exp_d ? val : 32'd0);
        end

        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, RS_FREE);
        #1;
        chk("final ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("final iwait",  {31'd0, bus.iwait},  32'd0);
        chk("final dwait",  {31'd0, bus.dwait},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
